mat_result_streamer: RTL

//  Read-out end of the matrix-multiply result path. Captures the packed M x N result vector
//  (element (m,n) at res_in[(m*N+n)*DATA_WIDTH +: DATA_WIDTH]) on a start pulse.

---
 rtl/mat_result_streamer.sv | 106 ++++++++++
 1 files changed

// File: rtl/mat_result_streamer.sv
// Streams a captured M x N result matrix out row-major, one element per valid/ready handshake.
// Optional MAT_STREAM_IDX_EN adds out_row/out_col coordinates alongside each element.
module mat_result_streamer #(
    parameter int unsigned M          = 3,
    parameter int unsigned N          = 3,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [DATA_WIDTH*M*N-1:0]    res_in,
    output logic                         busy,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
`ifdef MAT_STREAM_IDX_EN
    output logic [(M > 1 ? $clog2(M) : 1)-1:0] out_row,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0] out_col,
`endif
    output logic                         done
);

    localparam int unsigned Total = M * N;
    localparam int unsigned IdxW  = (Total > 1) ? $clog2(Total) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Total - 1);

`ifdef MAT_STREAM_IDX_EN
    localparam int unsigned RowW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned ColW = (N > 1) ? $clog2(N) : 1;
    localparam logic [ColW-1:0] LastCol = ColW'(N - 1);
`endif

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                    state;
    logic [DATA_WIDTH*M*N-1:0] shadow;
    logic [IdxW-1:0]           idx;
    logic [IdxW-1:0]           idx_inc;
    logic                      xfer;

    assign idx_inc = idx + IdxW'(1);
    assign xfer    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            shadow    <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
`ifdef MAT_STREAM_IDX_EN
            out_row   <= '0;
            out_col   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        shadow    <= res_in;
                        idx       <= '0;
                        out_data  <= res_in[DATA_WIDTH-1:0];
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        out_last  <= (Total == 1);
`ifdef MAT_STREAM_IDX_EN
                        out_row   <= '0;
                        out_col   <= '0;
`endif
                        state     <= StStream;
                    end
                end
                StStream: begin
                    if (xfer) begin
                        if (idx == LastIdx) begin
                            // out_data keeps the final element while idle
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= StIdle;
                        end else begin
                            idx      <= idx_inc;
                            out_data <= shadow[idx_inc*DATA_WIDTH +: DATA_WIDTH];
                            out_last <= (idx_inc == LastIdx);
`ifdef MAT_STREAM_IDX_EN
                            if (out_col == LastCol) begin
                                out_col <= '0;
                                out_row <= out_row + RowW'(1);
                            end else begin
                                out_col <= out_col + ColW'(1);
                            end
`endif
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
